// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: FSM state encoding and the
// fixed datapath depth (A/B -> M -> P).
package mac_pkg;

   localparam int MAC_LAT = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

endpackage

// File: rtl/mac_vpipe.sv
// Valid and first-sample shift pipeline that tracks each accepted sample
// through the M and P register stages of the multiply-accumulate datapath.
module mac_vpipe #(
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             accept_i,
   input  logic             first_i,
   output logic [DEPTH-1:0] v_o,
   output logic             f_last_o
);

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] f_q;

   // NOTE: non-blocking so every stage shifts from its pre-edge value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         f_q <= '0;
      end else begin
         v_q <= {v_q[DEPTH-2:0], accept_i};
         f_q <= {f_q[DEPTH-2:0], accept_i & first_i};
      end
   end

   assign v_o      = v_q;
   assign f_last_o = f_q[DEPTH-1];

endmodule

// File: rtl/mac_sequencer.sv
// Control sequencer for a pipelined DSP multiply-accumulate: clears P, feeds
// len samples through A/B -> M -> P and pulses done when P holds the result.
module mac_sequencer
   import mac_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int LAT   = MAC_LAT   // only 3 is supported
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ce_ab,
   output logic             ce_m,
   output logic             ce_p,
   output logic             clr_p,
   output logic             acc_en,
   output logic             busy,
   output logic             done
);

   localparam int DEPTH = LAT - 1;

   state_t           state_q;
   logic [CNT_W-1:0] remaining_q;
   logic             first_q;
   logic             busy_q;
   logic             done_q;
   logic             clr_p_q;
   logic             accept;
   logic             f_last;
   logic [DEPTH-1:0] v;

   assign in_ready = (state_q == S_RUN) && (remaining_q != '0);
   assign accept   = in_valid & in_ready;

   mac_vpipe #(
      .DEPTH(DEPTH)
   ) u_vpipe (
      .clk     (clk),
      .rst     (rst),
      .accept_i(accept),
      .first_i (first_q),
      .v_o     (v),
      .f_last_o(f_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         first_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         clr_p_q     <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         clr_p_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  remaining_q <= len;
                  busy_q      <= 1'b1;
                  if (len == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_CLEAR;
                     clr_p_q <= 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               state_q <= S_RUN;
               first_q <= 1'b1;
            end
            S_RUN: begin
               if (accept) begin
                  first_q     <= 1'b0;
                  remaining_q <= (remaining_q == '0) ? '0 : remaining_q - CNT_W'(1);
                  if (remaining_q == CNT_W'(1)) state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Last sample has left the M stage, so this is its ce_p cycle.
               if (v[DEPTH-2:0] == '0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ce_ab  = accept;
   assign ce_m   = v[0];
   assign ce_p   = v[DEPTH-1];
   assign acc_en = v[DEPTH-1] & ~f_last;
   assign clr_p  = clr_p_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: event timelines and a DSP datapath
// model are compared against rules computed from sample counts and cycles.
module tb_mac_sequencer;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             in_valid;
   logic             in_ready, ce_ab, ce_m, ce_p, clr_p, acc_en, busy, done;
   logic [7:0]       a_in, b_in;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int st_q[$], acc_q[$], cem_q[$], cep_q[$], clr_q[$], done_cyc[$];
   bit accen_q[$];
   int ir_cnt, busy_cnt, bad_cnt;
   logic [31:0] exp_sum;

   logic [7:0]  a_r, b_r;
   logic [31:0] m_r, p_r;

   mac_sequencer #(
      .CNT_W(CNT_W),
      .LAT  (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .len     (len),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .ce_ab   (ce_ab),
      .ce_m    (ce_m),
      .ce_p    (ce_p),
      .clr_p   (clr_p),
      .acc_en  (acc_en),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // Behavioural DSP slice driven by the sequencer's enables.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r <= '0; b_r <= '0; m_r <= '0; p_r <= '0;
      end else begin
         if (ce_ab) begin
            a_r <= a_in;
            b_r <= b_in;
         end
         if (ce_m) m_r <= 32'(a_r) * 32'(b_r);
         if (clr_p)     p_r <= '0;
         else if (ce_p) p_r <= acc_en ? p_r + m_r : m_r;
      end
   end

   // Event log sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (start) st_q.push_back(cyc);
      if (in_valid && in_ready) begin
         acc_q.push_back(cyc);
         exp_sum = exp_sum + 32'(a_in) * 32'(b_in);
      end
      if (ce_m) cem_q.push_back(cyc);
      if (ce_p) begin
         cep_q.push_back(cyc);
         accen_q.push_back(acc_en);
      end
      if (clr_p) clr_q.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
      if (in_ready) ir_cnt++;
      if (busy) busy_cnt++;
      if ((!busy || done) && (ce_ab || ce_m || ce_p || clr_p || acc_en || in_ready)) bad_cnt++;
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      st_q.delete(); acc_q.delete(); cem_q.delete(); cep_q.delete();
      clr_q.delete(); done_cyc.delete(); accen_q.delete();
      ir_cnt = 0; busy_cnt = 0; bad_cnt = 0; exp_sum = '0;
   endtask

   // Entered and left at posedge+1; start is held for 'hold' cycles.
   task automatic start_run(input int n, input int hold);
      clear_log();
      start = 1'b1;
      len   = CNT_W'(n);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      len   = CNT_W'($urandom);
   endtask

   // mode 0: valid held, 1: two-cycle bubble after sample 1,
   // 2: random valid, 3: valid held plus a stray start during RUN.
   task automatic feed(input int mode, output bit timed_out);
      int bub = 0;
      bit restarted = 1'b0;
      timed_out = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         a_in = 8'($urandom);
         b_in = 8'($urandom);
         start = 1'b0;
         case (mode)
            1: begin
               if (acc_q.size() == 1 && bub < 2) begin
                  in_valid = 1'b0;
                  bub++;
               end else in_valid = 1'b1;
            end
            2: in_valid = ($urandom_range(0, 3) != 0);
            3: begin
               in_valid = 1'b1;
               if (acc_q.size() == 2 && !restarted) begin
                  start = 1'b1;
                  len = CNT_W'(7);
                  restarted = 1'b1;
               end
            end
            default: in_valid = 1'b1;
         endcase
         @(posedge clk);
         #1;
         if (done_cyc.size() != 0) begin
            timed_out = 1'b0;
            break;
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic check_run(input string nm, input int n, input int ir_exp);
      int e_cep = 0, e_cem = 0, e_acc = 0;
      int d, la;
      repeat (4) @(posedge clk);
      #1;
      d  = (done_cyc.size() > 0) ? done_cyc[0] : -1;
      la = (acc_q.size() > 0) ? acc_q[acc_q.size()-1] : -100;
      check({nm, "_accepts"}, acc_q.size(), n);
      check({nm, "_done_count"}, done_cyc.size(), 1);
      check({nm, "_busy_cycles"}, busy_cnt, d - st_q[0]);
      check({nm, "_idle_enables"}, bad_cnt, 0);
      if (ir_exp >= 0) check({nm, "_ready_cycles"}, ir_cnt, ir_exp);
      if (n == 0) begin
         check({nm, "_done_cycle"}, d, st_q[0] + 1);
         check({nm, "_enables"}, clr_q.size() + cem_q.size() + cep_q.size(), 0);
      end else begin
         check({nm, "_clr_count"}, clr_q.size(), 1);
         if (clr_q.size() > 0) check({nm, "_clr_cycle"}, clr_q[0], st_q[0] + 1);
         check({nm, "_ce_m_count"}, cem_q.size(), n);
         check({nm, "_ce_p_count"}, cep_q.size(), n);
         for (int i = 0; i < n && i < acc_q.size(); i++) begin
            if (i < cem_q.size() && cem_q[i] != acc_q[i] + 1) e_cem++;
            if (i < cep_q.size() && cep_q[i] != acc_q[i] + 2) e_cep++;
            if (i < accen_q.size() && accen_q[i] != (i != 0)) e_acc++;
         end
         check({nm, "_ce_m_timing_errs"}, e_cem, 0);
         check({nm, "_ce_p_timing_errs"}, e_cep, 0);
         check({nm, "_acc_en_errs"}, e_acc, 0);
         check({nm, "_done_latency"}, d, la + 3);
         check({nm, "_p_result"}, p_r, exp_sum);
      end
   endtask

   task automatic run(input string nm, input int n, input int mode, input int ir_exp);
      bit to;
      start_run(n, 1);
      feed(mode, to);
      check({nm, "_timeout"}, to, 0);
      check_run(nm, n, ir_exp);
   endtask

   initial begin
      bit to;
      rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; a_in = '0; b_in = '0;
      clear_log();
      #2;
      check("reset_outputs", {in_ready, ce_ab, ce_m, ce_p, clr_p, acc_en, busy, done}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      run("len4", 4, 0, 4);

      run("bubble3", 3, 1, 5);
      if (acc_q.size() >= 2) check("bubble_acc_gap", acc_q[1] - acc_q[0], 3);
      if (cep_q.size() >= 2) check("bubble_ce_p_gap", cep_q[1] - cep_q[0], 3);

      run("len0", 0, 0, 0);

      start_run(0, 3);
      repeat (6) @(posedge clk);
      #1;
      check("start_on_done_count", done_cyc.size(), 2);
      if (done_cyc.size() == 2) begin
         check("start_on_done_first", done_cyc[0], st_q[0] + 1);
         check("start_on_done_second", done_cyc[1], st_q[0] + 3);
      end
      check("start_on_done_enables", bad_cnt + clr_q.size() + cep_q.size(), 0);

      run("restart5", 5, 3, 5);

      start_run(6, 1);
      to = 1'b1;
      for (int c = 0; c < 200; c++) begin
         in_valid = 1'b1;
         a_in = 8'($urandom);
         b_in = 8'($urandom);
         @(posedge clk);
         #1;
         if (acc_q.size() == 6) begin
            to = 1'b0;
            break;
         end
      end
      in_valid = 1'b0;
      check("drain_reach_timeout", to, 0);
      check("drain_ce_m", ce_m, 1);
      #1 rst = 1'b1;
      #1;
      check("rst_async_outputs", {in_ready, ce_ab, ce_m, ce_p, clr_p, acc_en, busy, done}, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("rst_no_done", done_cyc.size(), 0);

      run("after_rst2", 2, 0, 2);
      run("len255", 255, 2, -1);
      for (int r = 0; r < 3; r++) run("random", int'($urandom_range(1, 20)), 2, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not reach its summary in time");
      $fatal(1, "watchdog expired");
   end

endmodule
